// File: rtl/seg_scan_ctrl.sv
//-----------------------------------------------------------------------------
// seg_scan_ctrl
//
// Time-multiplexed driver for an 8-digit, common-anode 7-segment display.
// Each digit owns one scan slot made of a blanking interval (everything
// dark, to stop ghosting while the anodes switch) followed by a show
// interval. New content is written into a shadow copy at any time and
// moves to the display copy only at the frame boundary, so a frame is
// never torn.
//
// Parameters
//   DIGIT_TICKS  clock cycles each digit is shown per slot (>= 1)
//   BLANK_TICKS  clock cycles of all-off blanking before each slot (>= 1)
//
// Ports
//   clk         system clock
//   rst         asynchronous, active-high reset
//   load        one-cycle strobe: capture data/dp_in/digit_en into shadow
//   data[31:0]  eight hex nibbles, nibble k drives digit k
//   dp_in[7:0]  decimal point per digit, 1 = lit
//   digit_en    per-digit enable, 1 = digit lit in its slot
//   seg[6:0]    active-low segments, bit 0 = a ... bit 6 = g (registered)
//   dp          active-low decimal point (registered)
//   an[7:0]     active-low anode selects, bit k = digit k (registered)
//   pending     shadow holds content not yet shown
//   frame_done  one-cycle pulse after the last show cycle of digit 7
//-----------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int DIGIT_TICKS = 100000,
    parameter int BLANK_TICKS = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] data,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  digit_en,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [7:0]  an,
    output logic        pending,
    output logic        frame_done
);

    localparam int MAX_TICKS = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
    localparam int CW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_TICKS - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_t;

    // Scan position
    state_t         r_state;
    logic [2:0]     r_digit;
    logic [CW-1:0]  r_cnt;

    // Shadow copy (written by load) and display copy (what is scanned)
    logic [31:0]    r_sh_data;
    logic [7:0]     r_sh_dp;
    logic [7:0]     r_sh_en;
    logic           r_pending;

    logic [31:0]    r_disp_data;
    logic [7:0]     r_disp_dp;
    logic [7:0]     r_disp_en;

    // Registered outputs
    logic [6:0]     r_seg;
    logic           r_dp;
    logic [7:0]     r_an;
    logic           r_frame_done;

    // Combinational helpers
    logic           w_last_tick;
    logic           w_frame_end;
    logic [3:0]     w_nibble;
    logic [6:0]     w_seg_nxt;
    logic           w_dp_nxt;
    logic [7:0]     w_an_nxt;

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    always_comb begin
        w_last_tick = (r_state == ST_SHOW) ? (r_cnt == DIGIT_LAST)
                                           : (r_cnt == BLANK_LAST);
        w_frame_end = (r_state == ST_SHOW) && (r_digit == 3'd7) &&
                      (r_cnt == DIGIT_LAST);
        w_nibble    = r_disp_data[{r_digit, 2'b00} +: 4];

        // Default: everything dark (blanking or a disabled digit's slot)
        w_an_nxt    = '1;
        w_seg_nxt   = '1;
        w_dp_nxt    = 1'b1;
        if ((r_state == ST_SHOW) && r_disp_en[r_digit]) begin
            w_an_nxt  = ~(8'h01 << r_digit);
            w_seg_nxt = hex_glyph(w_nibble);
            w_dp_nxt  = ~r_disp_dp[r_digit];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_BLANK;
            r_digit      <= '0;
            r_cnt        <= '0;
            r_sh_data    <= '0;
            r_sh_dp      <= '0;
            r_sh_en      <= '0;
            r_pending    <= 1'b0;
            r_disp_data  <= '0;
            r_disp_dp    <= '0;
            r_disp_en    <= '0;
            r_seg        <= '1;
            r_dp         <= 1'b1;
            r_an         <= '1;
            r_frame_done <= 1'b0;
        end else begin
            // Outputs follow the scan position with one cycle of latency
            r_seg        <= w_seg_nxt;
            r_dp         <= w_dp_nxt;
            r_an         <= w_an_nxt;
            r_frame_done <= w_frame_end;

            // Slot sequencing: counter restarts on every state change
            if (w_last_tick) begin
                r_cnt <= '0;
                if (r_state == ST_BLANK) begin
                    r_state <= ST_SHOW;
                end else begin
                    r_state <= ST_BLANK;
                    r_digit <= r_digit + 3'd1;
                end
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
            end

            // Last load wins; a load on the boundary cycle lands in the
            // shadow while the old shadow content is moved to the display.
            if (load) begin
                r_sh_data <= data;
                r_sh_dp   <= dp_in;
                r_sh_en   <= digit_en;
            end

            if (w_frame_end && r_pending) begin
                r_disp_data <= r_sh_data;
                r_disp_dp   <= r_sh_dp;
                r_disp_en   <= r_sh_en;
            end

            if (load) begin
                r_pending <= 1'b1;
            end else if (w_frame_end) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign an         = r_an;
    assign pending    = r_pending;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
//-----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//
// Directed bench for seg_scan_ctrl with DIGIT_TICKS=4, BLANK_TICKS=2
// (6-cycle slots, 48-cycle frames). Outputs are sampled on the falling
// edge. Position j (1..48) counts falling edges after the frame boundary:
// digit k blanks at j = 6k+1, 6k+2 and shows at j = 6k+3 .. 6k+6;
// frame_done is high at j = 48.
//-----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    localparam int DT    = 4;
    localparam int BT    = 2;
    localparam int SLOT  = DT + BT;
    localparam int FRAME = 8 * SLOT;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [31:0] data;
    logic [7:0]  dp_in;
    logic [7:0]  digit_en;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  an;
    logic        pending;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;

    // Standard active-low hex glyphs, gfedcba
    logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    seg_scan_ctrl #(
        .DIGIT_TICKS (DT),
        .BLANK_TICKS (BT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data       (data),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .pending    (pending),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Random junk on the data inputs while load is low; must never be captured
    task automatic idle_inputs();
        load     = 1'b0;
        data     = $urandom;
        dp_in    = 8'($urandom);
        digit_en = 8'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " an"},   32'(an),         32'hFF);
        chk({tag, " seg"},  32'(seg),        32'h7F);
        chk({tag, " dp"},   32'(dp),         32'h1);
        chk({tag, " fd"},   32'(frame_done), 32'h0);
        chk({tag, " pend"}, 32'(pending),    32'h0);
    endtask

    // Walk positions j = 1..last_j of one frame, checking outputs against the
    // expected displayed content (d, p, e) and the pending flag, and issuing
    // up to two loads (driven at the falling edge of position l1_j / l2_j).
    task automatic run_frame(
        input string       tag,
        input logic [31:0] d,
        input logic [7:0]  p,
        input logic [7:0]  e,
        input logic        pend0,
        input int          last_j,
        input int          l1_j,
        input logic [31:0] l1_d,
        input logic [7:0]  l1_p,
        input logic [7:0]  l1_e,
        input int          l2_j,
        input logic [31:0] l2_d,
        input logic [7:0]  l2_p,
        input logic [7:0]  l2_e
    );
        logic        pend;
        logic [15:0] exp_v;
        logic [3:0]  nib;
        int          k;
        int          r;
        pend = pend0;
        for (int j = 1; j <= last_j; j++) begin
            @(negedge clk);
            if (load)
                pend = 1'b1;
            else if (j == FRAME)
                pend = 1'b0;
            k = (j - 1) / SLOT;
            r = (j - 1) % SLOT;
            if (r < BT || !e[k]) begin
                exp_v = {8'hFF, 7'h7F, 1'b1};
            end else begin
                nib   = d[4*k +: 4];
                exp_v = {~(8'h01 << k), GLYPH[nib], ~p[k]};
            end
            chk($sformatf("%s j=%0d an_seg_dp", tag, j), {16'h0, an, seg, dp}, {16'h0, exp_v});
            chk($sformatf("%s j=%0d frame_done", tag, j), 32'(frame_done), 32'(j == FRAME));
            chk($sformatf("%s j=%0d pending", tag, j), 32'(pending), 32'(pend));
            if (j == l1_j) begin
                load = 1'b1; data = l1_d; dp_in = l1_p; digit_en = l1_e;
            end else if (j == l2_j) begin
                load = 1'b1; data = l2_d; dp_in = l2_p; digit_en = l2_e;
            end else begin
                idle_inputs();
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_async");
        @(negedge clk);
        check_reset_outputs("rst_held");
        rst = 1'b0;

        // Dark frame after reset; load digits 7..0 with dp on digit 0
        run_frame("F0", 32'h0, 8'h00, 8'h00, 1'b0, FRAME,
                  10, 32'h76543210, 8'h01, 8'hFF, 0, 32'h0, 8'h00, 8'h00);
        // Shows 76543210; a mid-frame load of alternate-digit enables waits
        run_frame("F1", 32'h76543210, 8'h01, 8'hFF, 1'b0, FRAME,
                  20, 32'h76543210, 8'h00, 8'hAA, 0, 32'h0, 8'h00, 8'h00);
        // Only odd slots lit; two loads two cycles apart, last one wins
        run_frame("F2", 32'h76543210, 8'h00, 8'hAA, 1'b0, FRAME,
                  15, 32'h11111111, 8'h00, 8'hFF, 17, 32'h22222222, 8'h80, 8'hFF);
        // All 2s; a load mid-frame, then another on the boundary cycle
        run_frame("F3", 32'h22222222, 8'h80, 8'hFF, 1'b0, FRAME,
                  10, 32'h89ABCDEF, 8'h00, 8'hFF, 47, 32'hFEDCBA98, 8'h0F, 8'h0F);
        // Earlier shadow shown, boundary load still pending
        run_frame("F4", 32'h89ABCDEF, 8'h00, 8'hFF, 1'b1, FRAME,
                  0, 32'h0, 8'h00, 8'h00, 0, 32'h0, 8'h00, 8'h00);
        run_frame("F5", 32'hFEDCBA98, 8'h0F, 8'h0F, 1'b0, FRAME,
                  5, 32'h13579BDF, 8'hAA, 8'hFF, 0, 32'h0, 8'h00, 8'h00);
        // Stop inside digit 5's show interval with a load pending
        run_frame("F6", 32'h13579BDF, 8'hAA, 8'hFF, 1'b0, 34,
                  20, 32'hCAFEF00D, 8'hFF, 8'hFF, 0, 32'h0, 8'h00, 8'h00);

        rst = 1'b1;
        #1 check_reset_outputs("rst_mid");
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("rst_mid_held");
        rst = 1'b0;

        // Scan restarts at digit 0 with everything dark, then ten more frames
        run_frame("F7", 32'h0, 8'h00, 8'h00, 1'b0, FRAME,
                  0, 32'h0, 8'h00, 8'h00, 0, 32'h0, 8'h00, 8'h00);
        for (int f = 0; f < 10; f++) begin
            run_frame($sformatf("R%0d", f), 32'h0, 8'h00, 8'h00, 1'b0, FRAME,
                      0, 32'h0, 8'h00, 8'h00, 0, 32'h0, 8'h00, 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIGIT_TICKS, default 100000, meaning clock cycles each digit is driven per scan slot (1 ms at 100 MHz); legal range >= 1.
REQ-002 SHALL have parameter BLANK_TICKS, default 1000, meaning clock cycles of all-off blanking before each digit slot; legal range >= 1.
REQ-003 SHALL have port clk  input  1  system clock; one clock domain.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port load  input  1  one-cycle request to capture data/dp_in/digit_en into the shadow registers.
REQ-006 SHALL have port data  input  32  eight hex nibbles; nibble k (bits 4k+3:4k) is shown on digit k.
REQ-007 SHALL have port dp_in  input  8  decimal point per digit, 1 = lit.
REQ-008 SHALL have port digit_en  input  8  per-digit enable, 1 = digit lit in its slot.
REQ-009 SHALL have port seg  output  7  active-low segments, bit 0 = a ... bit 6 = g.
REQ-010 SHALL have port dp  output  1  active-low decimal point.
REQ-011 SHALL have port an  output  8  active-low anode selects, bit k = digit k.
REQ-012 SHALL have port pending  output  1  high while shadow holds data not yet applied to the display.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse at the end of each full 8-digit scan.

Function
REQ-014 SHALL scan digits 0,1,...,7 in order, wrapping 7 -> 0; each slot = BLANK_TICKS cycles of state BLANK, then DIGIT_TICKS cycles of state SHOW; frame = 8*(BLANK_TICKS+DIGIT_TICKS) cycles.
REQ-015 SHALL in BLANK drive an = 8'hFF, seg = 7'h7F, dp = 1.
REQ-016 SHALL in SHOW for digit k drive an with only bit k low when display enable bit k = 1, else an = 8'hFF, seg = 7'h7F, dp = 1 (disabled digits keep their time slot).
REQ-017 SHALL in SHOW for an enabled digit drive seg with the standard active-low hex glyph of display nibble k (0->1000000, 1->1111001, 2->0100100, 8->0000000, A->0001000, F->0001110) and dp = ~display dp bit k.
REQ-018 SHALL register seg, dp, an, frame_done; each reflects the internal state with exactly one clock of latency and never glitches.
REQ-019 SHALL on load = 1 capture data, dp_in, digit_en into shadow registers and set pending on the next edge; load while pending overwrites the shadow (last wins).
REQ-020 SHALL apply the shadow to the display registers only on the last SHOW cycle of digit 7 (frame boundary) if pending = 1, clearing pending on that edge; the display never changes mid-frame.
REQ-021 SHALL, when load coincides with the frame-boundary cycle, apply the previous shadow contents, store the new load in the shadow, and keep pending = 1 for the next frame.
REQ-022 SHALL assert frame_done for exactly one output cycle following the last SHOW cycle of digit 7, whether or not an update occurred.
REQ-023 SHALL size the tick counter to $clog2(max(DIGIT_TICKS,BLANK_TICKS)) bits minimum, reloading it to 0 on every state change with no extra idle cycles.

Reset
REQ-024 SHALL on rst = 1 immediately (asynchronously) force an = 8'hFF, seg = 7'h7F, dp = 1, frame_done = 0, pending = 0.
REQ-025 SHALL on rst clear display and shadow registers to 0 (data, dp, digit_en), set state BLANK, digit index 0, counter 0.
REQ-026 SHALL after rst deassertion start with digit 0 BLANK; since display digit_en = 0, all digits stay dark until the first load is applied at a frame boundary.
REQ-027 SHALL abort any scan and discard pending data when rst asserts mid-frame.

Verification (DIGIT_TICKS=4, BLANK_TICKS=2, frame = 48 cycles)
REQ-028 SHALL cover: reset, load data=32'h76543210, dp_in=8'h01, digit_en=8'hFF -> pending=1 until first frame_done; next frame digit k shows glyph k for 4 cycles after 2 blank cycles, dp low only on digit 0.
REQ-029 SHALL cover: digit_en=8'b1010_1010 -> an stays 8'hFF in slots 0,2,4,6; slots 1,3,5,7 go low; frame length still 48 cycles.
REQ-030 SHALL cover: load 32'h11111111 mid-frame, then load 32'h22222222 two cycles later -> current frame unchanged, next frame shows all 2s.
REQ-031 SHALL cover: load asserted exactly on the frame-boundary cycle -> the earlier shadow is shown next frame, pending stays 1, new value shown the frame after.
REQ-032 SHALL cover: rst asserted during SHOW of digit 5 with pending=1 -> an=8'hFF, pending=0 immediately; after release, scan restarts at digit 0, all dark.
REQ-033 SHALL cover: frame_done pulses exactly once every 48 cycles over 10 frames, never two consecutive cycles.
